// File: rtl/uart_pkg.sv
// Shared UART types and baud arithmetic. The receiver and the transmitter both
// take their prescaler divisor from here.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int HALF_BIT           = OVERSAMPLE_DEFAULT / 2;

  // Rounded number of system clocks per oversample tick.
  function automatic int calc_div(input longint clk_freq, input longint baud,
                                  input longint oversample);
    longint den;
    den = baud * oversample;
    return int'((clk_freq + den / 2) / den);
  endfunction

  function automatic int half_bit(input int oversample);
    return oversample / 2;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample prescaler: one-cycle tick every DIV clocks. A synchronous clear
// holds the count at zero so the tick phase can be aligned to a start edge.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = ~i_clr && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, a one-entry valid/ready holding
// register, and one-cycle framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       FPGA_CLK1_50,
  input  logic       reset_n,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  localparam int            DIV       = calc_div(longint'(CLK_FREQ), longint'(BAUD),
                                                 longint'(OVERSAMPLE));
  localparam int            CW        = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] OS_LAST   = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(half_bit(OVERSAMPLE) - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_prev;
  logic                   w_rxd;
  logic                   w_start_edge;

  rx_state_t r_state;
  rx_state_t w_state_next;
  logic [CW-1:0] r_os_cnt;
  logic [CW-1:0] w_os_cnt_next;
  logic [2:0]    r_bit_idx;
  logic [2:0]    w_bit_idx_next;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_next;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_fe;
  logic          r_ovr;
  logic          w_load;
  logic          w_fe_set;
  logic          w_ovr_set;
  logic          w_clr;
  logic          w_tick;

  assign w_rxd = r_sync[SYNC_STAGES-1];

  // r_fill marks when the synchronizer holds real line samples rather than its
  // reset value, so a line already low at reset release never looks like an edge.
  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '1;
      r_fill <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], RxD};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_prev <= r_fill[SYNC_STAGES-1] & w_rxd;
    end
  end

  assign w_start_edge = r_prev & ~w_rxd;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clk   (FPGA_CLK1_50),
    .rst_n (reset_n),
    .i_clr (w_clr),
    .o_tick(w_tick)
  );

  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_os_cnt  <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_fe      <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_os_cnt  <= w_os_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_fe      <= w_fe_set;
      r_ovr     <= w_ovr_set;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_os_cnt_next  = r_os_cnt;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_load         = 1'b0;
    w_fe_set       = 1'b0;
    w_ovr_set      = 1'b0;
    w_clr          = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_clr         = 1'b1;
        w_os_cnt_next = '0;
        if (w_start_edge) begin
          w_state_next = START;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_os_cnt == HALF_LAST) begin
            w_os_cnt_next = '0;
            if (!w_rxd) begin
              w_state_next   = DATA;
              w_bit_idx_next = '0;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_os_cnt_next = r_os_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_os_cnt == OS_LAST) begin
            w_os_cnt_next           = '0;
            w_shift_next[r_bit_idx] = w_rxd;
            if (r_bit_idx == 3'd7) begin
              w_state_next = STOP;
            end else begin
              w_bit_idx_next = r_bit_idx + 1'b1;
            end
          end else begin
            w_os_cnt_next = r_os_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_os_cnt == OS_LAST) begin
            w_os_cnt_next = '0;
            if (!w_rxd) begin
              w_fe_set     = 1'b1;
              w_state_next = WAIT_IDLE;
            end else if (r_valid && !rx_ready) begin
              // Holding register still owned by the consumer: keep the old byte.
              w_ovr_set    = 1'b1;
              w_state_next = IDLE;
            end else begin
              w_load       = 1'b1;
              w_state_next = IDLE;
            end
          end else begin
            w_os_cnt_next = r_os_cnt + 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        w_clr         = 1'b1;
        w_os_cnt_next = '0;
        if (w_rxd) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign rx_data       = r_data;
  assign rx_valid      = r_valid;
  assign framing_error = r_fe;
  assign overrun       = r_ovr;
  assign busy          = (r_state != IDLE);

endmodule
